// File: rtl/key_buffer_reader_if.sv
// Keypoint buffer reader bus: buffer head/occupancy, pop strobe, keypoint
// stream towards the descriptor/matcher stage, and frame bookkeeping.
// The master modport is the reader; the slave modport is its environment.
interface key_buffer_reader_if;
   logic [9:0]  i_count;
   logic [11:0] i_head_sin;
   logic [11:0] i_head_cos;
   logic [9:0]  i_head_x;
   logic [9:0]  i_head_y;
   logic        i_frame_end;
   logic        o_hit;
   logic        o_valid;
   logic        i_ready;
   logic [11:0] o_sin;
   logic [11:0] o_cos;
   logic [9:0]  o_coor_x;
   logic [9:0]  o_coor_y;
   logic [9:0]  o_kp_total;
   logic        o_done;

   modport master (
      input  i_count, i_head_sin, i_head_cos, i_head_x, i_head_y,
      input  i_frame_end, i_ready,
      output o_hit, o_valid, o_sin, o_cos, o_coor_x, o_coor_y,
      output o_kp_total, o_done
   );

   modport slave (
      output i_count, i_head_sin, i_head_cos, i_head_x, i_head_y,
      output i_frame_end, i_ready,
      input  o_hit, o_valid, o_sin, o_cos, o_coor_x, o_coor_y,
      input  o_kp_total, o_done
   );
endinterface

// File: rtl/key_buffer_reader.sv
// Keypoint buffer reader: pops head entries from the keypoint buffer with a
// one-cycle hit, forwards them over valid/ready (one keypoint per cycle when
// downstream keeps up), enforces a per-frame budget of MAX_KP keypoints and
// pulses o_done once the buffer is drained after end-of-frame.
// Optional macro KEYBUF_RD_BORDER_EN: entries within BORDER pixels of the
// image edge are popped but dropped instead of forwarded.
module key_buffer_reader #(
   parameter logic [9:0] MAX_KP = 10'd100,
   parameter logic [9:0] BORDER = 10'd16,
   parameter logic [9:0] IMG_W  = 10'd640,
   parameter logic [9:0] IMG_H  = 10'd480
) (
   input  logic                i_clk,
   input  logic                i_rst,
   key_buffer_reader_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_fe_pending;
   logic        r_hit_q;      // a pop was issued last cycle
   logic [11:0] r_sin;
   logic [11:0] r_cos;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [9:0]  r_kp_total;

   logic        w_pop;        // pop the head entry this cycle
   logic        w_take;       // load the head entry into the output regs
   logic        w_fe;         // end-of-frame seen (registered or arriving now)
   logic        w_has;        // buffer holds at least one entry
   logic        w_room;       // frame budget not yet exhausted
   logic        w_reject;     // head entry lies in the excluded border band

   assign w_fe   = r_fe_pending | bus.i_frame_end;
   assign w_has  = (bus.i_count != 10'd0);
   assign w_room = (r_kp_total < MAX_KP);

`ifdef KEYBUF_RD_BORDER_EN
   assign w_reject = (bus.i_head_x <  BORDER)          |
                     (bus.i_head_x >= (IMG_W - BORDER)) |
                     (bus.i_head_y <  BORDER)          |
                     (bus.i_head_y >= (IMG_H - BORDER));
`else
   logic w_unused_geom;
   assign w_reject      = 1'b0;
   assign w_unused_geom = ^{BORDER, IMG_W, IMG_H};
`endif

   // Next-state and pop/take decisions for the reader FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_take      = 1'b0;
      case (r_state)
         IDLE: begin
            // Head fields are only trusted when no pop was issued last cycle.
            if (w_has && !r_hit_q) begin
               if (w_room) begin
                  w_pop       = 1'b1;
                  w_take      = ~w_reject;
                  w_state_nxt = w_reject ? IDLE : HOLD;
               end else begin
                  w_state_nxt = DISCARD;
               end
            end else if (!w_has && w_fe) begin
               w_state_nxt = DONE;
            end
         end
         HOLD: begin
            // Accepting the current keypoint; refill in the same cycle if possible.
            if (bus.i_ready) begin
               if (w_has && w_room) begin
                  w_pop  = 1'b1;
                  w_take = ~w_reject;
                  if (w_reject) begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         DISCARD: begin
            // Drain over-budget entries, spacing pops so each sees settled occupancy.
            if (w_has) begin
               w_pop = ~r_hit_q;
            end else begin
               w_state_nxt = w_fe ? DONE : IDLE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, end-of-frame flag and pop history registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_fe_pending <= 1'b0;
         r_hit_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_state      <= w_state_nxt;
         r_hit_q      <= w_pop;
         // A new end-of-frame wins over the clear performed in DONE.
         r_fe_pending <= bus.i_frame_end | (r_fe_pending & (r_state != DONE));
      end
   end

   // Output keypoint payload and per-frame keypoint counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         // NOTE: payload registers are reset because they drive visible outputs that must read 0.
         r_sin      <= '0;
         r_cos      <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_kp_total <= '0;
      end else begin
         if (w_take) begin
            r_sin <= bus.i_head_sin;
            r_cos <= bus.i_head_cos;
            r_x   <= bus.i_head_x;
            r_y   <= bus.i_head_y;
         end
         if (r_state == DONE) begin
            r_kp_total <= '0;
         end else if (w_take && w_room) begin
            r_kp_total <= r_kp_total + 10'd1;
         end
      end
   end

   // The pop strobe is combinational; keep it quiet while reset is held.
   assign bus.o_hit      = w_pop & ~i_rst;
   assign bus.o_valid    = (r_state == HOLD);
   assign bus.o_done     = (r_state == DONE);
   assign bus.o_sin      = r_sin;
   assign bus.o_cos      = r_cos;
   assign bus.o_coor_x   = r_x;
   assign bus.o_coor_y   = r_y;
   assign bus.o_kp_total = r_kp_total;

endmodule

// File: doc/key_buffer_reader.md
Name: key_buffer_reader

Overview:
- Consumer side of the keypoint buffer. Watches the buffer head entry and occupancy, and pops entries with a one-cycle hit pulse.
- Forwards each popped keypoint (coordinates plus sin/cos orientation) to the descriptor/matcher stage over a valid/ready handshake.
- Enforces a per-frame keypoint budget and signals frame completion once the buffer is drained after end-of-frame.

Parameters:
- MAX_KP, 10'd100, maximum keypoints forwarded per frame; entries beyond this are popped and discarded.
- BORDER, 10'd16, edge margin in pixels, used only with KEYBUF_RD_BORDER_EN.
- IMG_W, 10'd640, image width in pixels.
- IMG_H, 10'd480, image height in pixels.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_count  in  10  buffer occupancy (0..99).
- i_head_sin  in  12  head entry sin.
- i_head_cos  in  12  head entry cos.
- i_head_x  in  10  head entry x coordinate.
- i_head_y  in  10  head entry y coordinate.
- i_frame_end  in  1  one-cycle pulse: no more buffer writes for this frame.
- o_hit  out  1  one-cycle pop request to the buffer.
- o_valid  out  1  output keypoint valid.
- i_ready  in  1  downstream accepts.
- o_sin  out  12  registered keypoint sin.
- o_cos  out  12  registered keypoint cos.
- o_coor_x  out  10  registered keypoint x.
- o_coor_y  out  10  registered keypoint y.
- o_kp_total  out  10  keypoints forwarded in the current frame.
- o_done  out  1  one-cycle pulse: frame fully drained.

Behaviour:
- Reset: all outputs 0; state IDLE; fe_pending=0.
- Buffer contract: a hit in cycle N is visible in i_count/head at cycle N+1. The reader samples head fields only in a cycle where o_hit was not asserted in the previous cycle, or where the state guarantees post-pop data (HOLD).
- "Take" means: capture head into output regs, assert o_hit for that cycle, increment o_kp_total.
- States:
  - IDLE (o_valid=0):
    - i_count!=0 and o_kp_total<MAX_KP -> take, go HOLD.
    - i_count!=0 and o_kp_total==MAX_KP -> DISCARD.
    - i_count==0 and fe_pending -> DONE.
  - HOLD (o_valid=1, payload stable until accepted):
    - On i_valid&i_ready, if i_count!=0 and o_kp_total<MAX_KP -> take again in the same cycle (back-to-back, 1 keypoint/cycle); stay HOLD.
    - Else on accept -> IDLE.
    - No o_hit while stalled (i_ready=0).
  - DISCARD: assert o_hit each cycle while i_count!=0, never on two consecutive cycles; outputs unchanged, o_valid=0. When i_count==0: fe_pending -> DONE, else IDLE.
  - DONE: o_done=1 for one cycle; clear o_kp_total and fe_pending; -> IDLE.
- i_frame_end sets fe_pending in any state, including the cycle DONE clears it; set wins over clear.
- o_kp_total saturates at MAX_KP.
- Never assert o_hit when i_count==0.
- Reset asserted mid-frame: everything returns to reset values immediately; the in-flight output keypoint is lost.

Optional Feature:
- Macro KEYBUF_RD_BORDER_EN.
- Defined: at take, an entry with x<BORDER, x>=IMG_W-BORDER, y<BORDER or y>=IMG_H-BORDER is popped but not loaded or counted. The reader stays in or returns to IDLE, and o_valid stays 0 for that entry.
- Undefined: all entries are forwarded; BORDER, IMG_W and IMG_H are unused.

Test Plan:
- Count=1, head (x=100,y=50,sin=12'h3FF,cos=12'h001), i_ready=1 -> o_hit one cycle, next cycle o_valid=1 with that payload, o_kp_total=1.
- Count=3, i_ready held 1 -> three o_hit pulses on consecutive cycles, three accepted outputs in order, o_kp_total=3.
- i_ready=0 for 5 cycles with count=4 -> o_valid held, payload stable, exactly one o_hit total until ready rises.
- MAX_KP=2, count=5, then i_frame_end -> 2 forwarded; remaining 3 popped in DISCARD with o_hit never on consecutive cycles; o_done pulses once count=0; o_kp_total returns to 0.
- i_frame_end with count=0 in IDLE -> o_done next cycle. i_frame_end coincident with DONE -> second o_done after re-entering IDLE.
- KEYBUF_RD_BORDER_EN, head x=5,y=200 -> o_hit, no o_valid, o_kp_total unchanged. Same test without the macro -> entry forwarded.
- i_rst pulse while in HOLD -> o_valid=0, o_kp_total=0 immediately.
